// File: rtl/multi_alarm_mode.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_mode
// Purpose  : Mode sequencer and alarm controller for a multi-alarm clock.
//            - Cleans the mode, edit and acknowledge buttons into one-cycle
//              pulses. The two edit buttons auto-repeat while held.
//            - Steps mode_idx through clock mode (0) and one edit mode per
//              alarm. Edit pulses are routed to the clock or to the alarm
//              being edited.
//            - Detects alarm matches in clock mode and runs an
//              IDLE/RING(/SNOOZE) state machine with a ring timeout.
// Options  : `define MULTI_ALARM_SNOOZE_EN adds the SNOOZE state and the
//            SNOOZE_CYCLES parameter. When the macro is not defined, an ack
//            while ringing goes straight back to IDLE.
// Ports    : clk             - clock
//            reset           - asynchronous active-low reset
//            mode_btn        - debounced mode-advance button
//            in_edit_btns    - debounced edit buttons [1]=hours [0]=minutes
//            ack_btn         - debounced alarm acknowledge button
//            current_time    - running clock time
//            alarm_times     - packed alarm times, alarm k at [k*TIME_W +: TIME_W]
//            alarm_en        - per-alarm arm enables
//            clock_edit_btns - edit pulses routed to the clock
//            alarm_edit_btns - edit pulses for alarm k at [2k+1:2k]
//            display_time    - time selected for display
//            mode_idx        - 0 = clock mode, k = editing alarm k-1
//            alarm           - ringing indicator
//            alarm_src       - set of alarms that caused the current ring
// Revision : 1.0 - initial release
// ============================================================================
module multi_alarm_mode #(
   parameter int N_ALARMS    = 2,
   parameter int TIME_W      = 20,
   parameter int HOLD_N      = 11,
   parameter int RING_CYCLES = 2**20
`ifdef MULTI_ALARM_SNOOZE_EN
   ,
   parameter int SNOOZE_CYCLES = 2**22
`endif
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mode_btn,
   input  logic [1:0]                    in_edit_btns,
   input  logic                          ack_btn,
   input  logic [TIME_W-1:0]             current_time,
   input  logic [N_ALARMS*TIME_W-1:0]    alarm_times,
   input  logic [N_ALARMS-1:0]           alarm_en,
   output logic [1:0]                    clock_edit_btns,
   output logic [2*N_ALARMS-1:0]         alarm_edit_btns,
   output logic [TIME_W-1:0]             display_time,
   output logic [$clog2(N_ALARMS+1)-1:0] mode_idx,
   output logic                          alarm,
   output logic [N_ALARMS-1:0]           alarm_src
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_MODE_W = $clog2(N_ALARMS + 1);
   localparam logic [c_MODE_W-1:0] c_MODE_LAST = c_MODE_W'(N_ALARMS);

   // The repeat counter spans one auto-repeat period of 2^(HOLD_N-1) cycles.
   // HOLD_N=1 degenerates to a pulse on every held cycle.
   localparam int c_HOLD_W = (HOLD_N > 1) ? HOLD_N - 1 : 1;
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX =
      c_HOLD_W'((64'd1 << (HOLD_N - 1)) - 64'd1);

   // A single timer serves both the ring timeout and the snooze period,
   // because the FSM is only ever in one of those states at a time.
`ifdef MULTI_ALARM_SNOOZE_EN
   localparam int c_TMR_MAX = (RING_CYCLES > SNOOZE_CYCLES) ? RING_CYCLES : SNOOZE_CYCLES;
`else
   localparam int c_TMR_MAX = RING_CYCLES;
`endif
   localparam int c_TMR_W = $clog2(c_TMR_MAX + 1);
   localparam logic [c_TMR_W-1:0] c_RING_LAST = c_TMR_W'(RING_CYCLES - 1);
`ifdef MULTI_ALARM_SNOOZE_EN
   localparam logic [c_TMR_W-1:0] c_SNOOZE_LAST = c_TMR_W'(SNOOZE_CYCLES - 1);
`endif

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_RING   = 2'd1;
`ifdef MULTI_ALARM_SNOOZE_EN
   localparam logic [1:0] c_ST_SNOOZE = 2'd2;
`endif

   // ------------------------------------------------------------------------
   // Button conditioning
   // ------------------------------------------------------------------------
   // r_armed stays low for the first clock after reset releases. During that
   // cycle the button history is loaded without producing a pulse, so a
   // button that is already held at reset release is ignored until it is let
   // go and pressed again.
   logic r_armed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   logic r_mode_prev;
   logic r_ack_prev;
   logic r_mode_pulse;
   logic r_ack_pulse;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode_prev  <= 1'b0;
         r_ack_prev   <= 1'b0;
         r_mode_pulse <= 1'b0;
         r_ack_pulse  <= 1'b0;
      end else begin
         r_mode_prev  <= mode_btn;
         r_ack_prev   <= ack_btn;
         r_mode_pulse <= r_armed & mode_btn & ~r_mode_prev;
         r_ack_pulse  <= r_armed & ack_btn & ~r_ack_prev;
      end
   end

   // Edit buttons: pulse on the press, then once per period while held.
   // r_act marks a press that was recognised. This keeps a button held since
   // reset from auto-repeating.
   logic [1:0] w_edit_pulse;

   genvar gb;
   generate
      for (gb = 0; gb < 2; gb++) begin : g_edit
         logic                r_prev;
         logic                r_act;
         logic                r_pulse;
         logic [c_HOLD_W-1:0] r_cnt;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_prev  <= 1'b0;
               r_act   <= 1'b0;
               r_pulse <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_prev  <= in_edit_btns[gb];
               r_pulse <= 1'b0;
               if (!in_edit_btns[gb]) begin
                  r_act <= 1'b0;
                  r_cnt <= '0;
               end else if (r_armed && !r_prev) begin
                  r_act   <= 1'b1;
                  r_cnt   <= '0;
                  r_pulse <= 1'b1;
               end else if (r_act) begin
                  // The counter is 0 on the cycle after the press and reaches
                  // c_HOLD_MAX exactly one period after the previous pulse.
                  r_pulse <= (r_cnt == c_HOLD_MAX);
                  r_cnt   <= (r_cnt == c_HOLD_MAX) ? '0 : r_cnt + c_HOLD_W'(1);
               end
            end
         end

         assign w_edit_pulse[gb] = r_pulse;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Mode register
   // ------------------------------------------------------------------------
   logic [c_MODE_W-1:0] r_mode_idx;
   logic                w_mode_leave;

   // A mode pulse in clock mode always moves to an edit mode.
   assign w_mode_leave = r_mode_pulse && (r_mode_idx == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode_idx <= '0;
      end else if (r_mode_pulse) begin
         r_mode_idx <= (r_mode_idx == c_MODE_LAST) ? '0 : r_mode_idx + c_MODE_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Edit routing, display mux and match detection
   // ------------------------------------------------------------------------
   logic [N_ALARMS-1:0] w_hit;
   logic [N_ALARMS-1:0] w_match;
   logic [N_ALARMS-1:0] r_prev_hit;
   logic [TIME_W-1:0]   w_display;

   assign clock_edit_btns = (r_mode_idx == '0) ? w_edit_pulse : 2'b00;

   genvar ga;
   generate
      for (ga = 0; ga < N_ALARMS; ga++) begin : g_alarm
         assign alarm_edit_btns[2*ga +: 2] =
            (r_mode_idx == c_MODE_W'(ga + 1)) ? w_edit_pulse : 2'b00;

         // The raw equality condition is kept across cycles in r_prev_hit,
         // so a time that stays equal fires only once.
         assign w_hit[ga] = (r_mode_idx == '0) && alarm_en[ga] &&
                            (alarm_times[ga*TIME_W +: TIME_W] == current_time);
      end
   endgenerate

   assign w_match = w_hit & ~r_prev_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev_hit <= '0;
      end else begin
         r_prev_hit <= w_hit;
      end
   end

   always_comb begin
      w_display = current_time;
      for (int k = 0; k < N_ALARMS; k++) begin
         if (r_mode_idx == c_MODE_W'(k + 1)) begin
            w_display = alarm_times[k*TIME_W +: TIME_W];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Alarm state machine
   // ------------------------------------------------------------------------
   logic [1:0]          r_state;
   logic [N_ALARMS-1:0] r_src;
   logic [c_TMR_W-1:0]  r_timer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_ST_IDLE;
         r_src   <= '0;
         r_timer <= '0;
      end else if (w_mode_leave || (r_mode_idx != '0)) begin
         // Leaving clock mode silences everything in the same cycle.
         r_state <= c_ST_IDLE;
         r_src   <= '0;
         r_timer <= '0;
      end else begin
         case (r_state)
            c_ST_RING: begin
               // The ack is checked first, so a match in the same cycle is
               // dropped.
               if (r_ack_pulse) begin
`ifdef MULTI_ALARM_SNOOZE_EN
                  r_state <= c_ST_SNOOZE;
                  r_timer <= '0;
`else
                  r_state <= c_ST_IDLE;
                  r_src   <= '0;
                  r_timer <= '0;
`endif
               end else if (|w_match) begin
                  r_src   <= r_src | w_match;
                  r_timer <= '0;
               end else if (r_timer == c_RING_LAST) begin
                  r_state <= c_ST_IDLE;
                  r_src   <= '0;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + c_TMR_W'(1);
               end
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            c_ST_SNOOZE: begin
               if (r_ack_pulse) begin
                  r_state <= c_ST_IDLE;
                  r_src   <= '0;
                  r_timer <= '0;
               end else begin
                  r_src <= r_src | w_match;
                  if (r_timer == c_SNOOZE_LAST) begin
                     r_state <= c_ST_RING;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer + c_TMR_W'(1);
                  end
               end
            end
`endif
            default: begin
               // IDLE. Any unused encoding also recovers here.
               r_state <= c_ST_IDLE;
               r_src   <= '0;
               r_timer <= '0;
               if (!r_ack_pulse && (|w_match)) begin
                  r_state <= c_ST_RING;
                  r_src   <= w_match;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign display_time = w_display;
   assign mode_idx     = r_mode_idx;
   assign alarm        = (r_state == c_ST_RING);
   assign alarm_src    = r_src;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_mode.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_alarm_mode
// Purpose  : Scoreboard bench for multi_alarm_mode with N_ALARMS=2, HOLD_N=3,
//            RING_CYCLES=16 and SNOOZE_CYCLES=8. The stimulus queues every
//            output event it expects. The monitor pops one entry each time the
//            outputs change or an edit pulse appears. An entry with cycle -1
//            has no fixed arrival cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_alarm_mode;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode_btn;
   logic [1:0]  in_edit_btns;
   logic        ack_btn;
   logic [19:0] current_time;
   logic [39:0] alarm_times;
   logic [1:0]  alarm_en;
   logic [1:0]  clock_edit_btns;
   logic [3:0]  alarm_edit_btns;
   logic [19:0] display_time;
   logic [1:0]  mode_idx;
   logic        alarm;
   logic [1:0]  alarm_src;

   multi_alarm_mode #(
      .N_ALARMS    (2),
      .TIME_W      (20),
      .HOLD_N      (3),
      .RING_CYCLES (16)
`ifdef MULTI_ALARM_SNOOZE_EN
      ,
      .SNOOZE_CYCLES (8)
`endif
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .mode_btn        (mode_btn),
      .in_edit_btns    (in_edit_btns),
      .ack_btn         (ack_btn),
      .current_time    (current_time),
      .alarm_times     (alarm_times),
      .alarm_en        (alarm_en),
      .clock_edit_btns (clock_edit_btns),
      .alarm_edit_btns (alarm_edit_btns),
      .display_time    (display_time),
      .mode_idx        (mode_idx),
      .alarm           (alarm),
      .alarm_src       (alarm_src)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      int          cyc;
      logic [1:0]  ce;
      logic [3:0]  ae;
      logic [1:0]  mode;
      logic [19:0] disp;
      logic        al;
      logic [1:0]  src;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic push(input string name, input int c, input logic [1:0] ce,
                       input logic [3:0] ae, input logic [1:0] mode,
                       input logic [19:0] disp, input logic al, input logic [1:0] src);
      exp_t e;
      e.name = name; e.cyc = c; e.ce = ce; e.ae = ae; e.mode = mode;
      e.disp = disp; e.al = al; e.src = src;
      q.push_back(e);
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   logic       m_first = 1'b1;
   logic       m_ev;
   logic [1:0] p_mode;
   logic       p_al;
   logic [1:0] p_src;
   exp_t       m_e;

   always @(negedge clk) begin
      m_ev = m_first || (clock_edit_btns != 2'b00) || (alarm_edit_btns != 4'b0000) ||
             (mode_idx != p_mode) || (alarm != p_al) || (alarm_src != p_src);
      if (m_ev) begin
         checks = checks + 1;
         if (q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_event: cyc=%0d ce=%b ae=%b mode=%0d alarm=%b src=%b, required no event",
                     cyc, clock_edit_btns, alarm_edit_btns, mode_idx, alarm, alarm_src);
         end else begin
            m_e = q.pop_front();
            if ((m_e.cyc >= 0 && m_e.cyc != cyc) || clock_edit_btns !== m_e.ce ||
                alarm_edit_btns !== m_e.ae || mode_idx !== m_e.mode ||
                display_time !== m_e.disp || alarm !== m_e.al || alarm_src !== m_e.src) begin
               errors = errors + 1;
               $display("FAIL %s: actual/required cyc=%0d/%0d ce=%b/%b ae=%b/%b mode=%0d/%0d disp=%h/%h alarm=%b/%b src=%b/%b",
                        m_e.name, cyc, m_e.cyc, clock_edit_btns, m_e.ce, alarm_edit_btns, m_e.ae,
                        mode_idx, m_e.mode, display_time, m_e.disp, alarm, m_e.al, alarm_src, m_e.src);
            end
         end
      end
      m_first = 1'b0;
      p_mode  = mode_idx;
      p_al    = alarm;
      p_src   = alarm_src;
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      mode_btn = 1'b1; tick(2);
      mode_btn = 1'b0; tick(2);
   endtask

   task automatic press_ack();
      ack_btn = 1'b1; tick(2);
      ack_btn = 1'b0; tick(2);
   endtask

   // Drive a non-matching time for two cycles so the next equality is new.
   task automatic gap_time(input logic [19:0] t);
      current_time = t; tick(2);
   endtask

   int c;

   initial begin
      reset        = 1'b0;
      mode_btn     = 1'b1;       // held across reset release: must be ignored
      in_edit_btns = 2'b01;      // held across reset release: must be ignored
      ack_btn      = 1'b0;
      current_time = 20'h00001;
      alarm_en     = 2'b00;
      alarm_times  = {20'h0B0B0, 20'h0A0A0};

      push("reset_state", -1, 2'b00, 4'b0000, 2'd0, 20'h00001, 1'b0, 2'b00);
      tick(3);
      reset = 1'b1;
      tick(6);
      mode_btn = 1'b0; in_edit_btns = 2'b00;
      tick(3);

      // Mode cycling with display tracking.
      push("mode_to_1", -1, 2'b00, 4'b0000, 2'd1, 20'h0A0A0, 1'b0, 2'b00); press_mode();
      push("mode_to_2", -1, 2'b00, 4'b0000, 2'd2, 20'h0B0B0, 1'b0, 2'b00); press_mode();
      push("mode_to_0", -1, 2'b00, 4'b0000, 2'd0, 20'h00001, 1'b0, 2'b00); press_mode();

      // Hours edit in clock mode goes to the clock.
      c = cyc;
      push("clock_hours", c + 1, 2'b10, 4'b0000, 2'd0, 20'h00001, 1'b0, 2'b00);
      in_edit_btns = 2'b10; tick(2); in_edit_btns = 2'b00; tick(2);

      // Hours edit while editing alarm 0.
      push("mode_to_1b", -1, 2'b00, 4'b0000, 2'd1, 20'h0A0A0, 1'b0, 2'b00); press_mode();
      c = cyc;
      push("alarm0_hours", c + 1, 2'b00, 4'b0010, 2'd1, 20'h0A0A0, 1'b0, 2'b00);
      in_edit_btns = 2'b10; tick(2); in_edit_btns = 2'b00; tick(2);

      // Auto-repeat on alarm 1 minutes: pulses at 1, 5 and 9 after the press.
      push("mode_to_2b", -1, 2'b00, 4'b0000, 2'd2, 20'h0B0B0, 1'b0, 2'b00); press_mode();
      c = cyc;
      push("repeat_1", c + 1, 2'b00, 4'b0100, 2'd2, 20'h0B0B0, 1'b0, 2'b00);
      push("repeat_5", c + 5, 2'b00, 4'b0100, 2'd2, 20'h0B0B0, 1'b0, 2'b00);
      push("repeat_9", c + 9, 2'b00, 4'b0100, 2'd2, 20'h0B0B0, 1'b0, 2'b00);
      in_edit_btns = 2'b01; tick(10); in_edit_btns = 2'b00; tick(3);
      push("mode_to_0b", -1, 2'b00, 4'b0000, 2'd0, 20'h00001, 1'b0, 2'b00); press_mode();

      // Match on alarm 1, timeout after 16 cycles, no re-fire while held.
      alarm_times[20 +: 20] = 20'h12345; alarm_en = 2'b10;
      current_time = 20'h12345;
      c = cyc;
      push("ring_alarm1",    c + 1,  2'b00, 4'b0000, 2'd0, 20'h12345, 1'b1, 2'b10);
      push("ring_timeout",   c + 17, 2'b00, 4'b0000, 2'd0, 20'h12345, 1'b0, 2'b00);
      tick(30);

      // Ack and an alarm 0 match in the same cycle: the ack wins.
      gap_time(20'h00111);
      alarm_times = {20'h00200, 20'h00300}; alarm_en = 2'b11;
      current_time = 20'h00200;
      c = cyc;
      push("ring_for_ack", c + 1, 2'b00, 4'b0000, 2'd0, 20'h00200, 1'b1, 2'b10);
      tick(3);
      ack_btn = 1'b1;
      c = cyc;
`ifdef MULTI_ALARM_SNOOZE_EN
      push("ack_beats_match", c + 2, 2'b00, 4'b0000, 2'd0, 20'h00300, 1'b0, 2'b10);
      push("ack_snooze_off",  c + 5, 2'b00, 4'b0000, 2'd0, 20'h00300, 1'b0, 2'b00);
`else
      push("ack_beats_match", c + 2, 2'b00, 4'b0000, 2'd0, 20'h00300, 1'b0, 2'b00);
`endif
      tick(1);
      current_time = 20'h00300;   // alarm 0 matches during the ack pulse cycle
      tick(1);
      ack_btn = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
      tick(1);
      ack_btn = 1'b1; tick(2); ack_btn = 1'b0;
`endif
      tick(12);

      // A mode press while ringing drops the alarm with the mode change.
      gap_time(20'h00222);
      alarm_times[20 +: 20] = 20'h00400; alarm_en = 2'b10;
      current_time = 20'h00400;
      c = cyc;
      push("ring_for_mode", c + 1, 2'b00, 4'b0000, 2'd0, 20'h00400, 1'b1, 2'b10);
      tick(3);
      push("mode_exit_ring", -1, 2'b00, 4'b0000, 2'd1, 20'h00300, 1'b0, 2'b00); press_mode();
      push("mode_to_2c",     -1, 2'b00, 4'b0000, 2'd2, 20'h00400, 1'b0, 2'b00); press_mode();
      current_time = 20'h00500; tick(1);
      push("mode_to_0c",     -1, 2'b00, 4'b0000, 2'd0, 20'h00500, 1'b0, 2'b00); press_mode();

      // Reset asserted between clock edges while ringing.
      alarm_times[20 +: 20] = 20'h00600;
      current_time = 20'h00600;
      c = cyc;
      push("ring_for_reset", c + 1, 2'b00, 4'b0000, 2'd0, 20'h00600, 1'b1, 2'b10);
      tick(4);
      #1;
      // No clock edge falls between this point and the next falling edge.
      push("async_reset", cyc, 2'b00, 4'b0000, 2'd0, 20'h00600, 1'b0, 2'b00);
      reset = 1'b0;
      tick(1);
      current_time = 20'h00601;
      tick(1);
      reset = 1'b1;
      tick(3);

`ifdef MULTI_ALARM_SNOOZE_EN
      // Snooze: 8 quiet cycles, ring again with the same source, then an ack
      // clears the ring.
      alarm_times[0 +: 20] = 20'h00700; alarm_en = 2'b01;
      current_time = 20'h00700;
      c = cyc;
      push("ring_for_snooze", c + 1, 2'b00, 4'b0000, 2'd0, 20'h00700, 1'b1, 2'b01);
      tick(3);
      ack_btn = 1'b1;
      c = cyc;
      push("snooze_enter",  c + 2,  2'b00, 4'b0000, 2'd0, 20'h00700, 1'b0, 2'b01);
      push("snooze_expire", c + 10, 2'b00, 4'b0000, 2'd0, 20'h00700, 1'b1, 2'b01);
      tick(2); ack_btn = 1'b0; tick(10);
      ack_btn = 1'b1;
      c = cyc;
      push("snooze_second_ack", c + 2, 2'b00, 4'b0000, 2'd0, 20'h00700, 1'b0, 2'b00);
      tick(2); ack_btn = 1'b0; tick(5);
      press_ack();
`endif

      tick(5);
      while (q.size() > 0) begin
         m_e = q.pop_front();
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: event never seen, required cyc=%0d alarm=%b src=%b mode=%0d",
                  m_e.name, m_e.cyc, m_e.al, m_e.src, m_e.mode);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_alarm_mode.md
MULTI_ALARM_MODE -- requirements
Module: multi_alarm_mode

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N_ALARMS, default 2: number of alarm channels, range 1..8.
REQ-003 Parameter TIME_W, default 20: width of one packed time word.
REQ-004 Parameter HOLD_N, default 11: auto-repeat period of 2^(HOLD_N-1) cycles.
REQ-005 Parameter RING_CYCLES, default 2^20: ring timeout in cycles.
REQ-006 Port clk, input, 1 bit: clock.
REQ-007 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-008 Port mode_btn, input, 1 bit: debounced mode-advance button.
REQ-009 Port in_edit_btns, input, 2 bits: debounced hours (bit 1) and minutes (bit 0) edit buttons.
REQ-010 Port ack_btn, input, 1 bit: debounced alarm acknowledge button.
REQ-011 Port current_time, input, TIME_W bits: running clock time.
REQ-012 Port alarm_times, input, N_ALARMS*TIME_W bits: alarm k occupies bits [k*TIME_W +: TIME_W].
REQ-013 Port alarm_en, input, N_ALARMS bits: per-alarm arm enables.
REQ-014 Port clock_edit_btns, output, 2 bits: edit pulses routed to the clock.
REQ-015 Port alarm_edit_btns, output, 2*N_ALARMS bits: edit pulses for alarm k at bits [2k+1:2k].
REQ-016 Port display_time, output, TIME_W bits: time to display.
REQ-017 Port mode_idx, output, $clog2(N_ALARMS+1) bits: 0 = clock mode, k = edit alarm k-1.
REQ-018 Port alarm, output, 1 bit: ringing indicator.
REQ-019 Port alarm_src, output, N_ALARMS bits: latched one-hot-or set of alarms that caused ringing.

Function
REQ-020 Each edit button SHALL produce a registered one-cycle pulse in the cycle after its rising edge, and SHALL repeat the pulse every 2^(HOLD_N-1) cycles while held.
REQ-021 mode_btn and ack_btn SHALL each produce a single one-cycle pulse per rising edge, with no repeat.
REQ-022 A mode pulse SHALL increment mode_idx, wrapping from N_ALARMS to 0.
REQ-023 Edit-pulse routing:
- mode_idx 0: pulses go to clock_edit_btns.
- mode_idx k: pulses go to bits [2k-1:2k-2] of alarm_edit_btns.
- All other edit outputs SHALL be 0.
REQ-024 display_time SHALL be current_time when mode_idx is 0, otherwise alarm k-1; it is combinational from the registered mode_idx.
REQ-025 A match on alarm k SHALL be: mode_idx==0, alarm_en[k]==1, alarm k equal to current_time, and no match on alarm k in the previous cycle. A time held constant therefore re-fires only after it changes.
REQ-026 The FSM SHALL have states IDLE and RING, plus SNOOZE when the snooze feature is compiled in.
REQ-027 IDLE -> RING on any match; alarm SHALL assert in the following cycle with alarm_src equal to the matching set.
REQ-028 In RING, further matches SHALL be OR-ed into alarm_src and SHALL restart the timeout counter.
REQ-029 In RING, a timeout after RING_CYCLES cycles SHALL return the FSM to IDLE and clear alarm_src.
REQ-030 When mode_idx leaves 0, the FSM SHALL go to IDLE from any state and clear alarm_src in the same cycle.
REQ-031 When an ack pulse and a match occur in the same cycle, the ack SHALL win and the match SHALL be discarded.
REQ-032 alarm SHALL be 1 only in RING.

Reset
REQ-033 While reset is 0, all of the following SHALL hold asynchronously: mode_idx=0, FSM=IDLE, alarm=0, alarm_src=0, all edit pulses 0, repeat and timeout counters 0, previous-match flags 0.
REQ-034 If a button is already held when reset releases, it SHALL NOT generate a pulse.

Configuration
REQ-035 Macro MULTI_ALARM_SNOOZE_EN, when defined:
- Adds parameter SNOOZE_CYCLES (default 2^22).
- An ack in RING SHALL go to SNOOZE with alarm=0 and alarm_src kept.
- When SNOOZE_CYCLES expire, the FSM SHALL return to RING.
- An ack in SNOOZE SHALL go to IDLE and clear alarm_src.
- Matches during SNOOZE SHALL be OR-ed into alarm_src.
REQ-036 When MULTI_ALARM_SNOOZE_EN is undefined, an ack in RING SHALL go directly to IDLE and clear alarm_src, and no SNOOZE logic SHALL exist.

Verification
All scenarios use N_ALARMS=2, HOLD_N=3, RING_CYCLES=16, SNOOZE_CYCLES=8.
REQ-037 Mode cycling: three mode_btn presses -> mode_idx goes 1, 2, 0; display_time tracks alarm0, alarm1, then current_time.
REQ-038 Auto-repeat: in_edit_btns[0] held 10 cycles at mode_idx=2 -> alarm_edit_btns[2] pulses at cycles 1, 5 and 9 after the rise; all other edit outputs stay 0.
REQ-039 Match and timeout: alarm1=current_time=0x12345, alarm_en=2'b10 -> alarm=1 and alarm_src=2'b10 one cycle later; alarm clears 16 cycles later; no re-fire while the time holds.
REQ-040 Ack priority: alarm0 matches in the same cycle as an ack pulse while RING -> FSM goes to IDLE and alarm_src=0.
REQ-041 Mode exit and reset: a mode press during RING -> alarm=0 next cycle; reset asserted mid-RING -> all outputs reach reset values without waiting for a clock edge.
REQ-042 Snooze (macro defined): ack in RING -> alarm=0 for 8 cycles, then 1 with alarm_src unchanged; a second ack -> IDLE.
